// File: rtl/vec_norm_div.sv
// Gram-Schmidt normalisation of a 4-element complex column: ||h|| by bit-serial restoring sqrt,
// then every element divided by the norm with a shared bit-serial restoring divider.
module vec_norm_div #(
   parameter int unsigned i_int  = 4,
   parameter int unsigned i_wide = 22,
   parameter int unsigned o_int  = 2,
   parameter int unsigned o_wide = 22
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_valid,
   input  logic [4*i_wide-1:0]   i_real,
   input  logic [4*i_wide-1:0]   i_imag,
   output logic                  o_busy,
   output logic                  o_valid,
   output logic [4*o_wide-1:0]   o_q_real,
   output logic [4*o_wide-1:0]   o_q_imag,
   output logic [i_wide:0]       o_norm,
   output logic                  o_zero
);
   localparam int unsigned W  = i_wide;
   localparam int unsigned FQ = o_wide - o_int;
   localparam int unsigned N  = o_wide - 1;       // quotient bits per element
   localparam int unsigned AW = 2 * W + 2;        // accumulator width
   localparam int unsigned RQ = W + 3;            // sqrt remainder width
   localparam int unsigned D  = W + FQ;           // dividend width
   localparam int unsigned RW = W + 2;            // divider remainder width
   localparam int unsigned HW = D - N;
   localparam int unsigned CW = $clog2(W + N + 2);

   if (i_int < 1 || i_int >= i_wide) begin : g_bad_int
      $error("vec_norm_div: i_int must lie in [1, i_wide)");
   end

   typedef enum logic [2:0] {StIdle, StSq, StSqrt, StDiv, StOut} state_t;

   state_t            r_state;
   logic [W-1:0]      r_buf [8];
   logic [o_wide-1:0] r_q [8];
   logic [2:0]        r_el;
   logic [CW-1:0]     r_cnt;
   logic [AW-1:0]     r_acc;
   logic [RQ-1:0]     r_srem;
   logic [W:0]        r_root;
   logic [RW-1:0]     r_rem;
   logic [N-1:0]      r_low;
   logic [W:0]        r_norm;
   logic              r_zero;
   logic              r_valid;

   logic [W-1:0]      w_sq_x, w_sq_abs;
   logic [2*W-1:0]    w_sq_ext, w_sq;
   logic [RQ-1:0]     w_sr, w_trial, w_sr_sub;
   logic              w_sr_ge;
   logic [W:0]        w_root_nx;
   logic [2:0]        w_ld_idx;
   logic [W-1:0]      w_ld_x, w_ld_abs;
   logic [D-1:0]      w_dvd;
   logic [RW-1:0]     w_ld_rem, w_dr, w_dr_sub;
   logic [N-1:0]      w_ld_low, w_q_nx;
   logic              w_dr_ge, w_neg;
   logic [o_wide-1:0] w_q_mag, w_q_val;

   // Squaring path: element selected by r_el, magnitude squared as unsigned.
   assign w_sq_x   = r_buf[r_el];
   assign w_sq_abs = w_sq_x[W-1] ? -w_sq_x : w_sq_x;
   assign w_sq_ext = {{W{1'b0}}, w_sq_abs};
   assign w_sq     = w_sq_ext * w_sq_ext;

   // Restoring sqrt: two radicand bits enter per cycle from the top of r_acc.
   assign w_sr      = {r_srem[RQ-3:0], r_acc[AW-1 -: 2]};
   assign w_trial   = {r_root, 2'b01};
   assign w_sr_ge   = w_sr >= w_trial;
   assign w_sr_sub  = w_sr - w_trial;
   assign w_root_nx = {r_root[W-1:0], w_sr_ge};

   // Divider preload: top dividend bits are already below the norm because q < 2^N.
   assign w_ld_idx = (r_state == StDiv) ? r_el + 3'd1 : 3'd0;
   assign w_ld_x   = r_buf[w_ld_idx];
   assign w_ld_abs = w_ld_x[W-1] ? -w_ld_x : w_ld_x;
   assign w_dvd    = {w_ld_abs, {FQ{1'b0}}};
   assign w_ld_rem = {{(RW-HW){1'b0}}, w_dvd[D-1:N]};
   assign w_ld_low = w_dvd[N-1:0];

   assign w_dr     = {r_rem[RW-2:0], r_low[N-1]};
   assign w_dr_ge  = w_dr >= {1'b0, r_norm};
   assign w_dr_sub = w_dr - {1'b0, r_norm};
   assign w_q_nx   = {r_low[N-2:0], w_dr_ge};
   assign w_neg    = r_buf[r_el][W-1];
   assign w_q_mag  = {1'b0, w_q_nx};
   assign w_q_val  = w_neg ? -w_q_mag : w_q_mag;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= StIdle;
         for (int i = 0; i < 8; i++) begin
            r_buf[i] <= '0;
            r_q[i]   <= '0;
         end
         r_el    <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_srem  <= '0;
         r_root  <= '0;
         r_rem   <= '0;
         r_low   <= '0;
         r_norm  <= '0;
         r_zero  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_valid <= 1'b0;
               if (i_valid) begin
                  for (int k = 0; k < 4; k++) begin
                     r_buf[2*k]   <= i_real[(3-k)*W +: W];
                     r_buf[2*k+1] <= i_imag[(3-k)*W +: W];
                  end
                  r_acc   <= '0;
                  r_el    <= '0;
                  r_state <= StSq;
               end
            end
            StSq: begin
               r_acc <= r_acc + {2'b00, w_sq};
               r_el  <= r_el + 3'd1;
               if (r_el == 3'd7) begin
                  r_srem  <= '0;
                  r_root  <= '0;
                  r_cnt   <= '0;
                  r_state <= StSqrt;
               end
            end
            StSqrt: begin
               r_acc  <= r_acc << 2;
               r_srem <= w_sr_ge ? w_sr_sub : w_sr;
               r_root <= w_root_nx;
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CW'(W)) begin
                  r_norm <= w_root_nx;
                  r_cnt  <= '0;
                  r_el   <= '0;
                  if (w_root_nx == '0) begin
                     r_zero <= 1'b1;
                     for (int i = 0; i < 8; i++) r_q[i] <= '0;
                     r_valid <= 1'b1;
                     r_state <= StOut;
                  end else begin
                     r_zero  <= 1'b0;
                     r_rem   <= w_ld_rem;
                     r_low   <= w_ld_low;
                     r_state <= StDiv;
                  end
               end
            end
            StDiv: begin
               r_rem <= w_dr_ge ? w_dr_sub : w_dr;
               r_low <= w_q_nx;
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(N - 1)) begin
                  r_q[r_el] <= w_q_val;
                  r_cnt     <= '0;
                  r_el      <= r_el + 3'd1;
                  if (r_el == 3'd7) begin
                     r_valid <= 1'b1;
                     r_state <= StOut;
                  end else begin
                     r_rem <= w_ld_rem;
                     r_low <= w_ld_low;
                  end
               end
            end
            StOut: begin
               r_valid <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_busy   = (r_state != StIdle);
   assign o_valid  = r_valid;
   assign o_norm   = r_norm;
   assign o_zero   = r_zero;
   assign o_q_real = {r_q[0], r_q[2], r_q[4], r_q[6]};
   assign o_q_imag = {r_q[1], r_q[3], r_q[5], r_q[7]};

endmodule

// File: tb/tb_vec_norm_div.sv
// Directed and random checks of vec_norm_div against an arithmetic reference model.
module tb_vec_norm_div;
   localparam int W  = 22;
   localparam int OW = 22;
   localparam int FQ = 20;

   logic            i_clk = 1'b0;
   logic            i_rst;
   logic            i_valid;
   logic [4*W-1:0]  i_real, i_imag;
   logic            o_busy, o_valid, o_zero;
   logic [4*OW-1:0] o_q_real, o_q_imag;
   logic [W:0]      o_norm;

   vec_norm_div dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .i_real   (i_real),
      .i_imag   (i_imag),
      .o_busy   (o_busy),
      .o_valid  (o_valid),
      .o_q_real (o_q_real),
      .o_q_imag (o_q_imag),
      .o_norm   (o_norm),
      .o_zero   (o_zero)
   );

   always #5 i_clk = ~i_clk;

   int n_vec = 0;
   int n_err = 0;
   logic signed [W-1:0] vin [8];
   longint exp_norm;
   longint exp_q [8];
   int exp_lat;

   function automatic longint isqrt(input longint a);
      longint lo, hi, mid;
      lo = 0;
      hi = longint'(1) << 24;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (mid * mid <= a) lo = mid;
         else hi = mid;
      end
      return lo;
   endfunction

   task automatic model();
      longint acc, mag, ax;
      acc = 0;
      for (int i = 0; i < 8; i++) acc += longint'(vin[i]) * longint'(vin[i]);
      exp_norm = isqrt(acc);
      for (int i = 0; i < 8; i++) begin
         ax = (vin[i] < 0) ? -longint'(vin[i]) : longint'(vin[i]);
         mag = (exp_norm == 0) ? 0 : (ax * (longint'(1) << FQ)) / exp_norm;
         exp_q[i] = (vin[i] < 0) ? -mag : mag;
      end
      exp_lat = (exp_norm == 0) ? 31 : 199;
   endtask

   task automatic check(input string tag, input longint obs, input longint expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   function automatic longint get_q(input int i);
      logic [OW-1:0] f;
      int k;
      k = i / 2;
      f = (i % 2 == 0) ? o_q_real[(3-k)*OW +: OW] : o_q_imag[(3-k)*OW +: OW];
      return longint'($signed(f));
   endfunction

   task automatic drive_vec();
      i_real = {vin[0], vin[2], vin[4], vin[6]};
      i_imag = {vin[1], vin[3], vin[5], vin[7]};
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge i_clk);
         #1;
         n++;
      end while (!o_valid && n < 400);
   endtask

   task automatic check_result(input string tag);
      check({tag, "_norm"}, longint'(o_norm), exp_norm);
      check({tag, "_zero"}, longint'(o_zero), (exp_norm == 0) ? 1 : 0);
      for (int i = 0; i < 8; i++) check($sformatf("%s_q%0d", tag, i), get_q(i), exp_q[i]);
   endtask

   task automatic run_vec(input string tag);
      int n;
      model();
      drive_vec();
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      check({tag, "_busy"}, longint'(o_busy), 1);
      wait_valid(n);
      check({tag, "_lat"}, longint'(n), longint'(exp_lat));
      check_result(tag);
      @(posedge i_clk);
      #1;
      check({tag, "_vdrop"}, longint'(o_valid), 0);
      check({tag, "_idle"}, longint'(o_busy), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, longint'(o_busy), 0);
      check({tag, "_valid"}, longint'(o_valid), 0);
      check({tag, "_norm"}, longint'(o_norm), 0);
      check({tag, "_zero"}, longint'(o_zero), 0);
      check({tag, "_qr"}, (o_q_real === '0) ? 1 : 0, 1);
      check({tag, "_qi"}, (o_q_imag === '0) ? 1 : 0, 1);
   endtask

   task automatic count_valids(input int cycles, output int cnt);
      cnt = 0;
      for (int c = 0; c < cycles; c++) begin
         @(posedge i_clk);
         #1;
         if (o_valid) cnt++;
      end
   endtask

   task automatic clear_vin();
      for (int i = 0; i < 8; i++) vin[i] = '0;
   endtask

   initial begin
      int n, cnt;
      int unsigned r;
      i_rst   = 1'b1;
      i_valid = 1'b0;
      i_real  = '0;
      i_imag  = '0;
      #12;
      check_all_zero("reset");
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk);
      #1;

      clear_vin();
      vin[0] = 22'sd262144;
      run_vec("unit");

      clear_vin();
      vin[0] = 22'sd786432;
      vin[3] = 22'sd1048576;
      run_vec("three_four");

      clear_vin();
      vin[0] = -22'sd786432;
      vin[1] = 22'sd1048576;
      run_vec("neg_trunc");

      clear_vin();
      run_vec("zero_vec");

      for (int i = 0; i < 8; i++) vin[i] = -22'sd2097152;
      run_vec("most_neg");
      check("most_neg_ref", exp_norm, 5931641);

      // i_valid pulses mid-SQRT (with different data) and in the OUT cycle must be ignored
      clear_vin();
      vin[0] = 22'sd786432;
      vin[3] = 22'sd1048576;
      model();
      drive_vec();
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (14) @(posedge i_clk);
      #1;
      i_real  = '1;
      i_imag  = '1;
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      drive_vec();
      wait_valid(n);
      check("pulse_lat", longint'(n + 15), 199);
      check_result("pulse");
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      check("pulse_out_idle", longint'(o_busy), 0);
      count_valids(250, cnt);
      check("pulse_extra_valid", longint'(cnt), 0);

      // reset in the middle of DIV aborts without a strobe
      clear_vin();
      vin[2] = 22'sd500000;
      vin[7] = -22'sd123456;
      drive_vec();
      i_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      repeat (100) @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      #1;
      check_all_zero("mid_rst");
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      count_valids(250, cnt);
      check("mid_rst_valid", longint'(cnt), 0);
      run_vec("after_rst");

      for (int t = 0; t < 6; t++) begin
         for (int i = 0; i < 8; i++) begin
            r = $urandom;
            vin[i] = $signed(r[W-1:0]) >>> $urandom_range(0, 20);
         end
         run_vec($sformatf("rand%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vec_norm_div.md
Name: vec_norm_div

Overview:
- Gram-Schmidt normalisation stage. It sits directly downstream of the dot/subtract stage and consumes its updated H column vector: 4 complex elements.
- Computes the column norm ||h||, which becomes the R diagonal entry.
- Divides every element by that norm to produce the Q column.
- Bit-serial: one accumulator, one restoring square-root, and one restoring divider, shared over time.

Parameters:
- i_int, 4, integer bits of the input elements, sign included.
- i_wide, 22, input element width. Input fraction bits F = i_wide - i_int.
- o_int, 2, integer bits of the Q output elements, sign included.
- o_wide, 22, Q output element width. Output fraction bits FQ = o_wide - o_int.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset: asynchronous, active-high.
- i_valid  in  1  input vector valid. Sampled only in IDLE.
- i_real  in  4*i_wide  packed {R0,R1,R2,R3}, signed, F fraction bits.
- i_imag  in  4*i_wide  packed {I0,I1,I2,I3}, signed.
- o_busy  out  1  high in every state except IDLE.
- o_valid  out  1  single-cycle result strobe.
- o_q_real  out  4*o_wide  packed {Q0..Q3} real parts, signed, FQ fraction bits.
- o_q_imag  out  4*o_wide  packed imaginary parts.
- o_norm  out  i_wide+1  unsigned ||h||, F fraction bits.
- o_zero  out  1  input vector was all zero.

Behaviour:
- Reset: i_rst is asynchronous, active-high; the clock is i_clk. Reset forces state IDLE. o_busy, o_valid, o_zero, o_norm, o_q_real and o_q_imag all reset to 0. All counters and the accumulator reset to 0.
- Reset mid-operation aborts the operation immediately. No o_valid is issued for the aborted vector.
- States: IDLE -> SQ -> SQRT -> DIV -> OUT -> IDLE.
- IDLE:
  - On i_valid, capture i_real and i_imag into internal buffers.
  - Clear the accumulator, go to SQ.
  - i_valid in any other state, including OUT, is ignored. Upstream must gate on o_busy.
- SQ, 8 cycles:
  - One element per cycle, order R0,I0,R1,I1,...,I3.
  - acc += x*x.
  - acc is unsigned, width 2*i_wide+2, fraction 2F. It cannot overflow: the maximum is 8*2^(2*i_wide-2).
- SQRT, i_wide+1 cycles:
  - Restoring bit-serial integer sqrt, one result bit per cycle, MSB first.
  - norm = floor(sqrt(acc)), width i_wide+1, fraction F. Register it to o_norm.
  - If norm == 0: set o_zero=1, Q outputs = 0, go directly to OUT.
  - Otherwise set o_zero=0 and go to DIV.
- DIV, 8*(o_wide-1) cycles:
  - Elements are processed in the same order as SQ.
  - Per element: restoring division of |x|*2^FQ by norm, o_wide-1 cycles, one quotient bit per cycle.
  - q = floor(|x|*2^FQ / norm). q <= 2^FQ is guaranteed, so it never saturates.
  - Result = x<0 ? -q : q, i.e. truncation toward zero. Write it into the corresponding o_q field.
- OUT, 1 cycle: o_valid=1, then IDLE.
- Latency:
  - Accepting edge e0. o_valid is high in the cycle after edge e0 + 8 + (i_wide+1) + 8*(o_wide-1). With defaults that is e199.
  - Zero-vector path: after edge e0 + 8 + (i_wide+1), i.e. e31.
- Output hold:
  - o_norm, o_zero, o_q_real and o_q_imag are valid while o_valid is high.
  - They hold until the next accepted vector's SQRT/DIV overwrite them.
  - o_q fields may change during DIV.
- Back-to-back: the next vector can be accepted on the edge that follows the OUT cycle, i.e. while in IDLE.

Test Plan:
- R0=262144 (1.0), all other components 0 -> o_norm=262144, Q0 real=1048576, all other Q fields 0, o_zero=0, o_valid exactly 199 edges after acceptance.
- R0=786432 (3.0), I1=1048576 (4.0), others 0 -> o_norm=1310720 (5.0), Q0 real=629145, Q1 imag=838860, all others 0.
- R0=-786432, I0=1048576, others 0 -> o_norm=1310720, Q0 real=-629145, Q0 imag=838860 (truncation toward zero).
- All components 0 -> o_zero=1, o_norm=0, all Q fields 0, o_valid 31 edges after acceptance.
- All 8 components -2097152 (most negative) -> accumulator 2^45, o_norm=5931641, every Q field -370727.
- Pulse i_valid mid-SQRT and in the OUT cycle -> both ignored, exactly one o_valid. Assert i_rst mid-DIV -> o_busy=0 and all outputs 0 after reset, no o_valid. A following vector then produces the correct result.
